// File: rtl/vedic_product_accumulator_if.sv
// vedic_product_accumulator_if: product-in / byte-out handshake bundle for the accumulator tile
interface vedic_product_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              ena;
  logic              clear;
  logic [CNT_W-1:0]  burst_len;
  logic [DATA_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              sat;
  logic              busy;
  modport master (
    output ena, clear, burst_len, prod_in, prod_valid, out_ready,
    input  prod_ready, out_byte, out_valid, out_last, sat, busy
  );
  modport slave (
    input  ena, clear, burst_len, prod_in, prod_valid, out_ready,
    output prod_ready, out_byte, out_valid, out_last, sat, busy
  );
endinterface

// File: rtl/vedic_product_accumulator.sv
// vedic_product_accumulator: sums a burst of multiplier products with saturation, emits the result as two bytes
module vedic_product_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input logic clk,
  input logic rst_n,
  vedic_product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, EMIT_LO, EMIT_HI} state_t;
  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_nxt, base;
  logic [ACC_W:0]    sum_full;
  logic [CNT_W:0]    cnt_q, cnt_d, len_q, len_d, len_eff, cnt_inc;
  logic [7:0]        out_byte_q, out_byte_d;
  logic [15:0]       acc16, nxt16;
  logic              sat_q, sat_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              first, accept;
  assign bus.prod_ready = rst_n & bus.ena & (state_q == ACCUM) & ~bus.clear;
  assign accept   = bus.prod_valid & bus.prod_ready;
  assign first    = cnt_q == '0;
  assign base     = first ? '0 : acc_q;
  assign sum_full = {1'b0, base} + (ACC_W+1)'(bus.prod_in);
  assign acc_nxt  = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
  // a zero burst_len selects the full 2^CNT_W burst via the extra MSB
  assign len_eff  = first ? {bus.burst_len == '0, bus.burst_len} : len_q;
  assign cnt_inc  = cnt_q + (CNT_W+1)'(1);
  assign acc16    = 16'(acc_q);
  assign nxt16    = 16'(acc_nxt);
  assign bus.out_byte  = out_byte_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = (cnt_q != '0) | (state_q != ACCUM);
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sat_d       = sat_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (bus.clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (bus.ena) begin
      case (state_q)
        ACCUM: if (accept) begin
          acc_d = acc_nxt;
          len_d = len_eff;
          sat_d = first ? 1'b0 : (sat_q | sum_full[ACC_W]);
          cnt_d = cnt_inc;
          if (cnt_inc == len_eff) begin
            cnt_d       = '0;
            state_d     = EMIT_LO;
            out_byte_d  = nxt16[7:0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end
        end
        EMIT_LO: if (bus.out_ready) begin
          out_byte_d = acc16[15:8];
          out_last_d = 1'b1;
          state_d    = EMIT_HI;
        end
        EMIT_HI: if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sat_q       <= 1'b0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_vedic_product_accumulator.sv
// tb_vedic_product_accumulator: drives a 16-bit and a 10-bit accumulator in lockstep against a burst-sum model
module tb_vedic_product_accumulator;
  logic clk, rst_n;
  int n_chk, n_fail;
  logic [7:0] eq16[$], eq10[$];
  bit s16, s10;
  int cnt, len, sum;
  vedic_product_accumulator_if #(.DATA_W(8), .CNT_W(4)) b16();
  vedic_product_accumulator_if #(.DATA_W(8), .CNT_W(4)) b10();
  vedic_product_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  vedic_product_accumulator #(.DATA_W(8), .ACC_W(10), .CNT_W(4)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));
  assign b10.ena        = b16.ena;
  assign b10.clear      = b16.clear;
  assign b10.burst_len  = b16.burst_len;
  assign b10.prod_in    = b16.prod_in;
  assign b10.prod_valid = b16.prod_valid;
  assign b10.out_ready  = b16.out_ready;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    eq16.delete();
    eq10.delete();
    cnt = 0;
    sum = 0;
  endtask
  task automatic finish_burst();
    logic [15:0] v;
    v = 16'(sum);
    eq16.push_back(v[7:0]);
    eq16.push_back(v[15:8]);
    s16 = 1'b0;
    v = sum > 1023 ? 16'd1023 : 16'(sum);
    eq10.push_back(v[7:0]);
    eq10.push_back(v[15:8]);
    s10 = sum > 1023;
  endtask
  // one clock: drive at negedge, check before the rising edge, advance the model
  task automatic cyc(input bit en, input bit clr, input bit pv, input logic [7:0] pin,
                     input logic [3:0] bl, input bit ordy);
    bit rdy;
    b16.ena = en; b16.clear = clr; b16.prod_valid = pv; b16.prod_in = pin;
    b16.burst_len = bl; b16.out_ready = ordy;
    #1;
    rdy = en && !clr && eq16.size() == 0;
    chk("ready16", b16.prod_ready, rdy);
    chk("ready10", b10.prod_ready, rdy);
    chk("busy16", b16.busy, cnt > 0 || eq16.size() > 0);
    chk("busy10", b10.busy, cnt > 0 || eq10.size() > 0);
    chk("valid16", b16.out_valid, eq16.size() > 0);
    chk("valid10", b10.out_valid, eq10.size() > 0);
    if (eq16.size() > 0) begin
      chk("byte16", b16.out_byte, eq16[0]);
      chk("last16", b16.out_last, eq16.size() == 1);
      chk("sat16", b16.sat, s16);
    end
    if (eq10.size() > 0) begin
      chk("byte10", b10.out_byte, eq10[0]);
      chk("last10", b10.out_last, eq10.size() == 1);
      chk("sat10", b10.sat, s10);
    end
    if (clr) model_reset();
    else if (en) begin
      if (eq16.size() > 0) begin
        if (ordy) begin
          void'(eq16.pop_front());
          void'(eq10.pop_front());
        end
      end else if (pv) begin
        if (cnt == 0) begin
          len = bl == 0 ? 16 : int'(bl);
          sum = 0;
        end
        sum += int'(pin);
        cnt++;
        if (cnt == len) begin
          finish_burst();
          cnt = 0;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic burst(input logic [3:0] bl, input int n, input logic [7:0] p);
    repeat (n) cyc(1, 0, 1, p, bl, 1);
  endtask
  task automatic drain(input int n);
    repeat (n) cyc(1, 0, 0, 8'd0, 4'd0, 1);
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    b16.ena = 1'b1; b16.clear = 1'b0; b16.prod_valid = 1'b1; b16.prod_in = 8'd0;
    b16.burst_len = 4'd0; b16.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", b16.prod_ready, 1'b0);
    chk("rst_valid", b16.out_valid, 1'b0);
    chk("rst_last", b16.out_last, 1'b0);
    chk("rst_byte", b16.out_byte, 8'h00);
    chk("rst_sat", b10.sat, 1'b0);
    chk("rst_busy", b10.busy, 1'b0);
    rst_n = 1'b1;
    cyc(1, 0, 1, 8'd6, 4'd4, 1);
    cyc(1, 0, 1, 8'd20, 4'd4, 1);
    cyc(1, 0, 1, 8'd225, 4'd4, 1);
    cyc(1, 0, 1, 8'd0, 4'd4, 1);
    chk("tp1_lo", b16.out_byte, 8'hFB);
    drain(3);
    burst(4'd0, 16, 8'd225);
    chk("tp2_lo", b16.out_byte, 8'h10);
    drain(3);
    cyc(1, 0, 1, 8'd20, 4'd1, 1);
    repeat (3) cyc(1, 0, 1, 8'd7, 4'd1, 0);
    chk("tp3_hold", b16.out_byte, 8'h14);
    drain(3);
    burst(4'd5, 5, 8'd225);
    chk("tp4_sat", b10.sat, 1'b1);
    chk("tp4_lo", b10.out_byte, 8'hFF);
    drain(3);
    cyc(1, 0, 1, 8'd6, 4'd1, 1);
    chk("tp4_unsat", b10.sat, 1'b0);
    drain(3);
    cyc(1, 0, 1, 8'd6, 4'd3, 1);
    cyc(1, 0, 1, 8'd20, 4'd3, 1);
    cyc(1, 1, 1, 8'd99, 4'd3, 1);
    burst(4'd3, 3, 8'd5);
    chk("tp5_lo", b16.out_byte, 8'h0F);
    drain(3);
    cyc(1, 0, 1, 8'd5, 4'd3, 1);
    repeat (4) cyc(0, 0, 1, 8'd77, 4'd1, 1);
    burst(4'd7, 2, 8'd5);
    drain(3);
    cyc(1, 0, 1, 8'd9, 4'd1, 1);
    cyc(1, 0, 0, 8'd0, 4'd1, 1);
    cyc(1, 0, 0, 8'd0, 4'd1, 0);
    chk("tp6_in_hi", b16.out_last, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", b16.out_valid, 1'b0);
    chk("arst_last", b16.out_last, 1'b0);
    chk("arst_busy", b16.busy, 1'b0);
    chk("arst_busy10", b10.busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    burst(4'd2, 2, 8'd9);
    chk("tp6_lo", b16.out_byte, 8'h12);
    drain(3);
    repeat (1500) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
          8'($urandom), 4'($urandom), $urandom_range(0, 1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vedic_product_accumulator.md
Name: vedic_product_accumulator

Overview:
- Downstream consumer of the 4x4 Vedic multiplier's registered 8-bit product stream.
- Accepts products over a valid/ready handshake and sums a programmable-length burst into a saturating accumulator.
- Emits the result as two bytes, low byte first, over a second valid/ready handshake.
- Allows the 8-bit output pins of the tile wrapper to return a multi-product dot-product or sum.

Parameters:
- DATA_W, 8, product input width (unsigned).
- ACC_W, 16, accumulator width; legal range DATA_W+1 .. 16. The output is zero-extended to 16 bits.
- CNT_W, 4, burst counter width; burst length ranges 1..2^CNT_W.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, tile enable; when low all state freezes.
- clear, input, 1, synchronous abort: drop the current burst and return to ACCUM with acc=0.
- burst_len, input, CNT_W, products per burst; 0 encodes 2^CNT_W. Latched on the first accept of each burst.
- prod_in, input, DATA_W, unsigned product from the multiplier.
- prod_valid, input, 1, prod_in valid.
- prod_ready, output, 1, accumulator can take a product.
- out_byte, output, 8, result byte.
- out_valid, output, 1, out_byte valid.
- out_ready, input, 1, downstream accepts out_byte.
- out_last, output, 1, high with the high (second) byte.
- sat, output, 1, set if the burst saturated; valid alongside out_valid; cleared at the start of the next burst.
- busy, output, 1, high when the burst count is nonzero or the FSM is not in ACCUM.

Behaviour:
- Reset (async, rst_n=0): FSM=ACCUM, acc=0, cnt=0, len_q=0, sat=0, out_valid=0, out_last=0, out_byte=0, prod_ready=0 while rst_n is low.
- All outputs are registered except prod_ready. prod_ready = ena & (state==ACCUM) & ~clear.
- Priority: rst_n > clear > ena=0 freeze > normal operation.
- Accept happens when prod_valid & prod_ready at a rising edge.
- ACCUM state:
  - On the first accept of a burst (cnt==0): len_q <= burst_len (0 maps to 2^CNT_W); acc <= prod_in; sat <= 0.
  - On later accepts: acc <= acc + prod_in, saturating at 2^ACC_W-1; sat <= 1 if the true sum exceeds that value (sticky).
  - cnt increments on each accept.
  - When an accept makes cnt == len_q: go to EMIT_LO next cycle; cnt <= 0; out_byte <= final sum[7:0]; out_valid <= 1; out_last <= 0.
  - The final sum includes the last product: one-cycle latency from the last accept to out_valid.
- EMIT_LO state: hold out_byte/out_valid until out_ready. On handshake: out_byte <= {zero-ext sum}[15:8]; out_last <= 1; go to EMIT_HI.
- EMIT_HI state: hold until out_ready. On handshake: out_valid <= 0; out_last <= 0; go to ACCUM. prod_ready rises in the same cycle the state reaches ACCUM.
- No product is accepted during EMIT states, so backpressure propagates upstream.
- ena=0: no accept, no handshake completes, all registers hold.
- clear=1: next edge gives state=ACCUM, acc=0, cnt=0, sat=0, out_valid=0, out_last=0. Any pending output bytes are discarded.
- burst_len changes mid-burst have no effect until the next burst.
- Simultaneous clear and accept: clear wins; the product is not accepted, since prod_ready is low.
- Reset mid-burst or mid-emit: immediate return to the reset values; no partial output.

Test Plan:
- Burst_len=4; products 6, 20, 225, 0 back-to-back with out_ready=1 -> bytes 0xFB (out_last=0) then 0x00 (out_last=1); sat=0; out_valid rises one cycle after the 4th accept.
- Burst_len=0; 16 products of 225 -> sum 3600: bytes 0x10 then 0x0E; busy high throughout; prod_ready low for exactly 2 cycles during the emit.
- Backpressure: burst_len=1, product 20, out_ready low for 3 cycles -> out_byte stays 0x14 and out_valid stays 1; prod_ready stays 0 with prod_valid held high; out_ready=1 then completes 0x14 followed by 0x00.
- Saturation: ACC_W=10, burst_len=5, five products of 225 -> bytes 0xFF then 0x03 (1023); sat=1. The next burst of 1×6 -> sat=0, bytes 0x06 then 0x00.
- Clear/ena: burst_len=3, accept 6 and 20, pulse clear, then 3×5 -> bytes 0x0F then 0x00 (earlier products discarded). ena=0 for 4 cycles mid-burst -> no accepts and unchanged result.
- Async reset: assert rst_n=0 between clock edges during EMIT_HI -> out_valid, out_last and busy drop to 0 immediately. After release, burst_len=2 with products 9, 9 -> bytes 0x12 then 0x00.
